// File: rtl/dff_pipe_syncasync_reset.sv
// rtl/dff_pipe_syncasync_reset.sv - valid-tagged register pipeline with async and sync reset
// Optional per-stage even parity with error injection when DFF_PIPE_PARITY_EN is defined.
module dff_pipe_syncasync_reset #(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic                       sync_reset,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           d,
`ifdef DFF_PIPE_PARITY_EN
    input  logic                       par_inject,
    output logic                       par_err,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i]  <= RESET_VALUE;
                stage_valid[i] <= 1'b0;
            end
        end else if (sync_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i]  <= RESET_VALUE;
                stage_valid[i] <= 1'b0;
            end
        end else if (en) begin
            stage_data[0]  <= d;
            stage_valid[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_data[i]  <= stage_data[i-1];
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // Counter tracks valid bits entering stage 0 versus leaving the last stage.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            occupancy <= '0;
        end else if (sync_reset) begin
            occupancy <= '0;
        end else if (en) begin
            if (in_valid && !stage_valid[DEPTH-1]) begin
                occupancy <= occupancy + OW'(1);
            end else if (!in_valid && stage_valid[DEPTH-1]) begin
                occupancy <= occupancy - OW'(1);
            end
        end
    end

    assign q         = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];

`ifdef DFF_PIPE_PARITY_EN
    logic [DEPTH-1:0] stage_par;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            stage_par <= '0;
        end else if (sync_reset) begin
            stage_par <= '0;
        end else if (en) begin
            stage_par[0] <= (^d) ^ par_inject;
            for (int i = 1; i < DEPTH; i++) begin
                stage_par[i] <= stage_par[i-1];
            end
        end
    end

    assign par_err = out_valid & ((^q) ^ stage_par[DEPTH-1]);
`endif

endmodule
